// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: weighted VC0/VC1 -> D0/D1 scheduler; ARB_STATS_EN adds per-destination push counters.
module vc_dest_arbiter #(
  parameter int DATA_W     = 6,
  parameter int DEST_BIT   = 4,
  parameter int VC0_WEIGHT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic              vc0_empty,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              vc1_empty,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] d_data,
  output logic              busy,
  output logic [7:0]        cnt_d0,
  output logic [7:0]        cnt_d1
);
  typedef enum logic {OFF, RUN} state_t;
  localparam logic [3:0] W = 4'(VC0_WEIGHT);
  state_t state;
  logic [3:0] wcnt;
  logic en, e0, e1, pop_any;
  logic [DATA_W-1:0] pop_word;
  always_comb begin
    en = state == RUN && active_in;
    e0 = !vc0_empty && !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
    e1 = !vc1_empty && !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
    vc1_pop = en && e1 && (!e0 || wcnt == W);
    vc0_pop = en && e0 && !vc1_pop;
    pop_any = vc0_pop || vc1_pop;
    pop_word = vc1_pop ? vc1_data : vc0_data;
    busy = pop_any || d0_push || d1_push;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= OFF;
      wcnt <= '0;
      d0_push <= 1'b0;
      d1_push <= 1'b0;
      d_data <= '0;
    end else begin
      state <= active_in ? RUN : OFF;
      wcnt <= (vc1_pop || vc1_empty) ? 4'd0 : (vc0_pop && e1 && wcnt != W) ? wcnt + 4'd1 : wcnt;
      d0_push <= pop_any && !pop_word[DEST_BIT];
      d1_push <= pop_any && pop_word[DEST_BIT];
      if (pop_any) d_data <= pop_word;
    end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_d0 <= '0;
      cnt_d1 <= '0;
    end else begin
      if (d0_push && cnt_d0 != 8'hff) cnt_d0 <= cnt_d0 + 8'd1;
      if (d1_push && cnt_d1 != 8'hff) cnt_d1 <= cnt_d1 + 8'd1;
    end
`else
  assign cnt_d0 = '0;
  assign cnt_d1 = '0;
`endif
endmodule

// File: tb/tb_vc_dest_arbiter.sv
// tb_vc_dest_arbiter: scenario tasks with a push scoreboard; VC FIFOs are modelled as queues.
module tb_vc_dest_arbiter;
  logic clk = 0, reset = 1, active_in = 0;
  logic [5:0] vc0_data = 0, vc1_data = 0, d_data;
  logic vc0_empty = 1, vc1_empty = 1, d0_almost_full = 0, d1_almost_full = 0;
  logic vc0_pop, vc1_pop, d0_push, d1_push, busy;
  logic [7:0] cnt_d0, cnt_d1;
  logic [5:0] q0[$], q1[$];
  logic [7:0] sb[$];
  logic [7:0] e;
  logic p0, p1, s_d0, s_d1, s_busy;
  logic [5:0] s_dd;
  logic [7:0] s_c0, s_c1;
  int vec = 0, err = 0;

  vc_dest_arbiter dut (.clk(clk), .reset(reset), .active_in(active_in),
    .vc0_data(vc0_data), .vc0_empty(vc0_empty), .vc1_data(vc1_data), .vc1_empty(vc1_empty),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop), .d0_push(d0_push), .d1_push(d1_push),
    .d_data(d_data), .busy(busy), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1));

  always #5 clk = ~clk;

  task automatic refresh();
    vc0_empty = q0.size() == 0;
    vc0_data = vc0_empty ? 6'h0 : q0[0];
    vc1_empty = q1.size() == 0;
    vc1_data = vc1_empty ? 6'h0 : q1[0];
  endtask

  task automatic cycle();
    @(negedge clk);
    {p0, p1, s_d0, s_d1, s_dd, s_busy, s_c0, s_c1} = {vc0_pop, vc1_pop, d0_push, d1_push, d_data, busy, cnt_d0, cnt_d1};
    if (s_d0 || s_d1 || sb.size() != 0) begin
      vec++;
      if (sb.size() == 0) begin
        err++;
        $display("FAIL sb_extra push d1/d0/data=%b/%b/%h, expected no push", s_d1, s_d0, s_dd);
      end else begin
        e = sb.pop_front();
        if ({s_d1, s_d0, s_dd} !== e) begin
          err++;
          $display("FAIL sb_push d1/d0/data=%b/%b/%h, expected %b/%b/%h", s_d1, s_d0, s_dd, e[7], e[6], e[5:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    refresh();
  endtask

  task automatic chk_pop(input string name, input logic x0, input logic x1);
    vec++;
    if ({p0, p1} !== {x0, x1}) begin
      err++;
      $display("FAIL %s pop0/pop1=%b/%b, expected %b/%b", name, p0, p1, x0, x1);
    end
  endtask

  task automatic test_reset();
    cycle();
    vec++;
    if ({p0, p1, s_d0, s_d1, s_dd, s_busy, s_c0, s_c1} !== 0) begin
      err++;
      $display("FAIL reset_state outputs=%h, expected 0", {p0, p1, s_d0, s_d1, s_dd, s_busy, s_c0, s_c1});
    end
    reset = 0;
    q0.push_back(6'h05);
    q1.push_back(6'h01);
    refresh();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_pop("idle_pop", 0, 0);
      vec++;
      if (s_busy !== 1'b0) begin err++; $display("FAIL idle_busy busy=%b, expected 0", s_busy); end
    end
    active_in = 1;
    cycle();
    chk_pop("off_first", 0, 0);
    cycle();
    chk_pop("run_first", 1, 0);
    vec++;
    if (d0_push !== 1'b1) begin err++; $display("FAIL inflight d0_push=%b, expected 1", d0_push); end
    reset = 1;
    #1;
    vec++;
    if ({vc0_pop, vc1_pop, d0_push, d1_push, d_data, busy} !== 0) begin
      err++;
      $display("FAIL reset_mid outputs=%h, expected 0", {vc0_pop, vc1_pop, d0_push, d1_push, d_data, busy});
    end
    q0.delete();
    q1.delete();
    refresh();
    cycle();
    chk_pop("reset_pop", 0, 0);
    reset = 0;
    active_in = 0;
    cycle();
  endtask

  task automatic test_routing();
    active_in = 1;
    q0.push_back(6'h05);
    q0.push_back(6'h15);
    refresh();
    cycle();
    chk_pop("route_off", 0, 0);
    cycle();
    chk_pop("route_a", 1, 0);
    sb.push_back({2'b01, 6'h05});
    cycle();
    chk_pop("route_b", 1, 0);
    sb.push_back({2'b10, 6'h15});
    cycle();
    chk_pop("route_idle", 0, 0);
    cycle();
    vec++;
    if ({s_d0, s_d1, s_dd} !== {2'b00, 6'h15}) begin
      err++;
      $display("FAIL hold_data d0/d1/data=%b/%b/%h, expected 0/0/15", s_d0, s_d1, s_dd);
    end
  endtask

  task automatic test_weighting();
    for (int i = 0; i < 9; i++) q0.push_back(6'(i + 1));
    for (int i = 0; i < 3; i++) q1.push_back(6'(8'h20 + i));
    refresh();
    for (int k = 0, a = 0, b = 0; k < 12; k++) begin
      cycle();
      if (k % 4 == 3) begin
        chk_pop("weight_vc1", 0, 1);
        sb.push_back({2'b01, 6'(8'h20 + b)});
        b++;
      end else begin
        chk_pop("weight_vc0", 1, 0);
        sb.push_back({2'b01, 6'(a + 1)});
        a++;
      end
    end
    cycle();
    chk_pop("weight_done", 0, 0);
  endtask

  task automatic test_flow();
    d0_almost_full = 1;
    q0.push_back(6'h05);
    q1.push_back(6'h11);
    refresh();
    cycle();
    chk_pop("flow_vc1", 0, 1);
    sb.push_back({2'b10, 6'h11});
    cycle();
    chk_pop("flow_block", 0, 0);
    d0_almost_full = 0;
    cycle();
    chk_pop("flow_release", 1, 0);
    sb.push_back({2'b01, 6'h05});
    cycle();
    chk_pop("flow_done", 0, 0);
  endtask

  task automatic test_enable_drop();
    q0.push_back(6'h02);
    q0.push_back(6'h03);
    refresh();
    cycle();
    chk_pop("en_pop", 1, 0);
    sb.push_back({2'b01, 6'h02});
    active_in = 0;
    cycle();
    chk_pop("en_drop", 0, 0);
    vec++;
    if (s_busy !== 1'b1) begin err++; $display("FAIL en_busy busy=%b, expected 1", s_busy); end
    active_in = 1;
    cycle();
    chk_pop("en_off", 0, 0);
    cycle();
    chk_pop("en_resume", 1, 0);
    sb.push_back({2'b01, 6'h03});
    cycle();
    active_in = 0;
    cycle();
  endtask

  task automatic test_stats();
    logic [7:0] x0, x1, y0;
`ifdef ARB_STATS_EN
    {x0, x1, y0} = {8'd16, 8'd2, 8'd255};
`else
    {x0, x1, y0} = 0;
`endif
    vec++;
    if ({s_c0, s_c1} !== {x0, x1}) begin
      err++;
      $display("FAIL cnt_mid cnt_d0/cnt_d1=%0d/%0d, expected %0d/%0d", s_c0, s_c1, x0, x1);
    end
    for (int i = 0; i < 300; i++) q0.push_back(6'h01);
    refresh();
    active_in = 1;
    cycle();
    chk_pop("stats_off", 0, 0);
    for (int i = 0; i < 300; i++) begin
      cycle();
      chk_pop("stats_pop", 1, 0);
      sb.push_back({2'b01, 6'h01});
    end
    cycle();
    cycle();
    vec++;
    if ({s_c0, s_c1} !== {y0, x1}) begin
      err++;
      $display("FAIL cnt_sat cnt_d0/cnt_d1=%0d/%0d, expected %0d/%0d", s_c0, s_c1, y0, x1);
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_weighting();
    test_flow();
    test_enable_drop();
    test_stats();
    vec++;
    if (sb.size() != 0) begin err++; $display("FAIL sb_left entries=%0d, expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/vc_dest_arbiter.md
Name: vc_dest_arbiter

Overview:
- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1).
- Pops at most one word per cycle from VC0/VC1 and routes it to D0 or D1 by a destination bit in the word.
- Obeys destination almost-full flow control and a weighted priority (VC0 favoured, VC1 starvation-free).
- Enabled by the control FSM's active_out; sits between the VC FIFOs and the D FIFOs.

Parameters:
DATA_W, 6, word width of VC/D FIFO data
DEST_BIT, 4, index of the bit in the data word selecting the destination (0 -> D0, 1 -> D1)
VC0_WEIGHT, 3, consecutive VC0 grants allowed while VC1 is eligible before VC1 is forced (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
active_in  input  1  enable from control FSM; arbitration only while 1
vc0_data  input  DATA_W  show-ahead head word of VC0 FIFO
vc0_empty  input  1  VC0 FIFO empty
vc1_data  input  DATA_W  show-ahead head word of VC1 FIFO
vc1_empty  input  1  VC1 FIFO empty
d0_almost_full  input  1  D0 almost-full
d1_almost_full  input  1  D1 almost-full
vc0_pop  output  1  pop VC0 (combinational, same cycle as grant)
vc1_pop  output  1  pop VC1 (combinational)
d0_push  output  1  push D0 (registered)
d1_push  output  1  push D1 (registered)
d_data  output  DATA_W  data for D0/D1 push (registered)
busy  output  1  1 when a pop occurs this cycle or a push is pending
cnt_d0  output  8  words pushed to D0 (ARB_STATS_EN only)
cnt_d1  output  8  words pushed to D1 (ARB_STATS_EN only)

Behaviour:
- Reset values: all registered outputs 0, state OFF, wcnt 0, cnt_d0/cnt_d1 0. Pops are 0 while reset is asserted.
- Reset mid-operation: an in-flight push is dropped; the FIFOs are reset by the same signal.
- FSM states: OFF, RUN.
  - OFF -> RUN when active_in=1.
  - RUN -> OFF when active_in=0.
- Pops are gated by (state==RUN && active_in). On the cycle active_in falls, no pop occurs. A push registered from the prior cycle still completes.
- Eligibility:
  - VCx eligible = !vcx_empty && !almost_full of the destination selected by vcx_data[DEST_BIT].
- Grant, at most one per cycle:
  - Neither VC eligible: no grant.
  - Only one VC eligible: grant it. A VC blocked on its destination does not block the other VC.
  - Both eligible: grant VC1 if wcnt==VC0_WEIGHT, else grant VC0.
- wcnt (4 bits):
  - Increments on a VC0 grant while VC1 is eligible; saturates at VC0_WEIGHT.
  - Cleared on any VC1 grant, or on any cycle with vc1_empty=1.
  - Holds otherwise.
- Latency: a pop in cycle N produces dX_push=1 and d_data=popped word in cycle N+1. dX_push lasts exactly 1 cycle per word; d0_push and d1_push are never both 1.
- With no grant, d0_push=d1_push=0 next cycle and d_data holds its last value.
- Flow-control margin: because the push lags the decision by 1 cycle, destination almost-full thresholds must leave at least 2 free entries.
- busy = vc0_pop | vc1_pop | d0_push | d1_push.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - cnt_d0/cnt_d1 increment on each d0_push/d1_push.
  - Both saturate at 255 and reset to 0.
- Undefined:
  - Counters are not built; cnt_d0/cnt_d1 are driven constant 0.
  - Arbitration is unchanged.

Test Plan:
- Reset/idle: reset=1 mid-traffic -> all outputs 0 immediately. After release with active_in=0 and both VCs non-empty -> no pops, busy=0.
- Routing/latency: active_in=1, VC0 holds 0x05 (dest D0) then 0x15 (dest D1), VC1 empty -> vc0_pop in cycles N and N+1. Then d0_push with d_data=0x05 at N+1, d1_push with d_data=0x15 at N+2.
- Weighting: both VCs continuously non-empty with D0 destinations, VC0_WEIGHT=3 -> grant pattern VC0,VC0,VC0,VC1 repeating.
- Flow control: d0_almost_full=1, VC0 head dest D0, VC1 head dest D1 -> only vc1_pop. Drop d0_almost_full -> VC0 popped the next cycle.
- Enable drop: active_in 1->0 in the same cycle as an eligible head -> no pop that cycle. The previous cycle's push still appears; the state returns to OFF.
- Stats (ARB_STATS_EN): 300 pushes to D0 -> cnt_d0=255, cnt_d1=0. Without the macro, both read 0.
